// File: rtl/aes_host_sequencer.sv
// aes_host_sequencer
// Host-side front end for the AES/DRAM top. It assembles the 128-bit key and
// plaintext from 32-bit host words, runs the key-load and encrypt handshakes,
// captures the ciphertext and hands it back as four 32-bit words. It also counts
// DRAM read completions per encryption and traps stalled handshakes in ERR.
module aes_host_sequencer #(
   parameter int TIMEOUT_CYC = 4096,
   parameter int CNT_W       = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic             wr_sel,
   input  logic [31:0]      wr_data,
   input  logic             start,
   input  logic             clr_err,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [31:0]      rd_data,
   output logic [127:0]     Kin,
   output logic [127:0]     Din,
   output logic             Kdrdy,
   output logic             EN,
   input  logic             Kvld,
   input  logic             Dvld,
   input  logic [127:0]     Dout,
   input  logic             BSY,
   input  logic             Dload,
   output logic             key_ok,
   output logic             busy,
   output logic             timeout,
   output logic [CNT_W-1:0] dload_cnt
);

   localparam int TW = $clog2(TIMEOUT_CYC) + 1;

   typedef enum logic [2:0] {
      IDLE,
      KEY_REQ,
      KEY_WAIT,
      ENC_REQ,
      ENC_WAIT,
      DRAIN,
      ERR
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       k_cnt_q, k_cnt_d;
   logic [2:0]       d_cnt_q, d_cnt_d;
   logic [127:0]     key_q, key_d;
   logic [127:0]     din_q, din_d;
   logic [127:0]     cipher_q, cipher_d;
   logic [1:0]       ptr_q, ptr_d;
   logic             key_ok_q, key_ok_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] dload_cnt_q, dload_cnt_d;
   logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;

   logic [1:0]       k_slot;
   logic [1:0]       d_slot;
   logic             tmo_expired;
   logic [31:0]      rd_word;

   // A full block (count 4) restarts at slot 0 on the next write.
   assign k_slot      = (k_cnt_q == 3'd4) ? 2'd0 : k_cnt_q[1:0];
   assign d_slot      = (d_cnt_q == 3'd4) ? 2'd0 : d_cnt_q[1:0];
   assign tmo_expired = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

   // Next-state, datapath loads and handshake bookkeeping.
   always_comb begin
      state_d     = state_q;
      k_cnt_d     = k_cnt_q;
      d_cnt_d     = d_cnt_q;
      key_d       = key_q;
      din_d       = din_q;
      cipher_d    = cipher_q;
      ptr_d       = ptr_q;
      key_ok_d    = key_ok_q;
      timeout_d   = timeout_q;
      dload_cnt_d = dload_cnt_q;
      tmo_cnt_d   = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (key_ok_q && (d_cnt_q == 3'd4) && !BSY) begin
                  state_d = ENC_REQ;
               end
            end else if (wr_valid) begin
               if (wr_sel) begin
                  for (int i = 0; i < 4; i++) begin
                     if (k_slot == 2'(i)) begin
                        key_d[127-32*i -: 32] = wr_data;
                     end
                  end
                  if (k_slot == 2'd3) begin
                     state_d  = KEY_REQ;
                     key_ok_d = 1'b0;
                     k_cnt_d  = 3'd0;
                  end else begin
                     k_cnt_d = {1'b0, k_slot} + 3'd1;
                  end
               end else begin
                  for (int i = 0; i < 4; i++) begin
                     if (d_slot == 2'(i)) begin
                        din_d[127-32*i -: 32] = wr_data;
                     end
                  end
                  d_cnt_d = {1'b0, d_slot} + 3'd1;
               end
            end
         end
         KEY_REQ: begin
            state_d = KEY_WAIT;
         end
         KEY_WAIT: begin
            if (Kvld) begin
               key_ok_d = 1'b1;
               state_d  = IDLE;
            end else if (tmo_expired) begin
               state_d   = ERR;
               timeout_d = 1'b1;
               key_ok_d  = 1'b0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         ENC_REQ: begin
            dload_cnt_d = '0;
            state_d     = ENC_WAIT;
         end
         ENC_WAIT: begin
            if (Dload && (dload_cnt_q != {CNT_W{1'b1}})) begin
               dload_cnt_d = dload_cnt_q + CNT_W'(1);
            end
            if (Dvld) begin
               cipher_d = Dout;
               d_cnt_d  = 3'd0;
               ptr_d    = 2'd0;
               state_d  = DRAIN;
            end else if (tmo_expired) begin
               state_d   = ERR;
               timeout_d = 1'b1;
               key_ok_d  = 1'b0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         DRAIN: begin
            if (rd_ready) begin
               ptr_d = ptr_q + 2'd1;
               if (ptr_q == 2'd3) begin
                  state_d = IDLE;
               end
            end
         end
         ERR: begin
            if (clr_err) begin
               state_d   = IDLE;
               timeout_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         k_cnt_q     <= '0;
         d_cnt_q     <= '0;
         key_q       <= '0;
         din_q       <= '0;
         cipher_q    <= '0;
         ptr_q       <= '0;
         key_ok_q    <= 1'b0;
         timeout_q   <= 1'b0;
         dload_cnt_q <= '0;
         tmo_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         k_cnt_q     <= k_cnt_d;
         d_cnt_q     <= d_cnt_d;
         key_q       <= key_d;
         din_q       <= din_d;
         cipher_q    <= cipher_d;
         ptr_q       <= ptr_d;
         key_ok_q    <= key_ok_d;
         timeout_q   <= timeout_d;
         dload_cnt_q <= dload_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   // Select the ciphertext word currently offered to the host, MSW first.
   always_comb begin
      rd_word = cipher_q[127:96];
      case (ptr_q)
         2'd1:    rd_word = cipher_q[95:64];
         2'd2:    rd_word = cipher_q[63:32];
         2'd3:    rd_word = cipher_q[31:0];
         default: rd_word = cipher_q[127:96];
      endcase
   end

   assign wr_ready  = (state_q == IDLE) && !start;
   assign Kdrdy     = (state_q == KEY_REQ);
   assign EN        = (state_q == ENC_REQ);
   assign rd_valid  = (state_q == DRAIN);
   assign rd_data   = (state_q == DRAIN) ? rd_word : 32'd0;
   assign busy      = (state_q != IDLE);
   assign Kin       = key_q;
   assign Din       = din_q;
   assign key_ok    = key_ok_q;
   assign timeout   = timeout_q;
   assign dload_cnt = dload_cnt_q;

endmodule

// File: tb/tb_aes_host_sequencer.sv
// tb_aes_host_sequencer
// Drives the sequencer like a host plus a simple AES core responder and compares
// against expectations computed from the block's rules (word packing, one-cycle
// handshakes, saturating Dload count, timeout window).
module tb_aes_host_sequencer;

   localparam int TIMEOUT_CYC = 16;
   localparam int CNT_W       = 3;
   localparam int DL_MAX      = (1 << CNT_W) - 1;

   logic             CLK = 1'b0;
   logic             RST;
   logic             wr_valid;
   logic             wr_ready;
   logic             wr_sel;
   logic [31:0]      wr_data;
   logic             start;
   logic             clr_err;
   logic             rd_valid;
   logic             rd_ready;
   logic [31:0]      rd_data;
   logic [127:0]     Kin;
   logic [127:0]     Din;
   logic             Kdrdy;
   logic             EN;
   logic             Kvld;
   logic             Dvld;
   logic [127:0]     Dout;
   logic             BSY;
   logic             Dload;
   logic             key_ok;
   logic             busy;
   logic             timeout;
   logic [CNT_W-1:0] dload_cnt;

   int checks = 0;
   int passes = 0;

   logic [127:0] timeout_pt;

   aes_host_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
      .start(start), .clr_err(clr_err),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .Kin(Kin), .Din(Din), .Kdrdy(Kdrdy), .EN(EN),
      .Kvld(Kvld), .Dvld(Dvld), .Dout(Dout), .BSY(BSY), .Dload(Dload),
      .key_ok(key_ok), .busy(busy), .timeout(timeout), .dload_cnt(dload_cnt)
   );

   always #5 CLK = ~CLK;

   // Present one host word for one clock; the DUT must be idle so it is accepted.
   task automatic write_word(input logic sel, input logic [31:0] data);
      @(negedge CLK);
      wr_valid = 1'b1;
      wr_sel   = sel;
      wr_data  = data;
      @(negedge CLK);
      wr_valid = 1'b0;
      wr_data  = $urandom;
   endtask

   task automatic pulse_start();
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      wr_valid = 0; wr_sel = 0; wr_data = 0; start = 0; clr_err = 0; rd_ready = 0;
      Kvld = 0; Dvld = 0; Dout = 0; BSY = 0; Dload = 0;
      repeat (3) @(negedge CLK);
      checks++; if (Kin !== 128'd0) $display("[TB] FAIL reset_kin got=%h exp=0", Kin); else passes++;
      checks++; if (Din !== 128'd0) $display("[TB] FAIL reset_din got=%h exp=0", Din); else passes++;
      checks++; if (rd_data !== 32'd0) $display("[TB] FAIL reset_rd_data got=%h exp=0", rd_data); else passes++;
      checks++; if ({Kdrdy, EN, rd_valid, key_ok, busy, timeout} !== 6'd0)
         $display("[TB] FAIL reset_flags got=%b exp=000000", {Kdrdy, EN, rd_valid, key_ok, busy, timeout}); else passes++;
      checks++; if (dload_cnt !== '0) $display("[TB] FAIL reset_dload_cnt got=%0d exp=0", dload_cnt); else passes++;
      RST = 1'b0;
      @(negedge CLK);
      checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL reset_wr_ready got=%b exp=1", wr_ready); else passes++;
   endtask

   // start without a loaded key must be ignored; wr_ready drops while start is high.
   task automatic test_start_no_key(input logic [127:0] pt);
      for (int i = 0; i < 4; i++) write_word(1'b0, pt[127-32*i -: 32]);
      @(negedge CLK);
      start = 1'b1;
      #1;
      checks++; if (wr_ready !== 1'b0) $display("[TB] FAIL start_blocks_wr_ready got=%b exp=0", wr_ready); else passes++;
      @(negedge CLK);
      start = 1'b0;
      checks++; if ({EN, busy} !== 2'b00) $display("[TB] FAIL start_no_key got=%b exp=00", {EN, busy}); else passes++;
      checks++; if (Din !== pt) $display("[TB] FAIL din_pack got=%h exp=%h", Din, pt); else passes++;
   endtask

   task automatic test_key_load(input logic [127:0] key, input int kdelay);
      int pulses;
      for (int i = 0; i < 4; i++) write_word(1'b1, key[127-32*i -: 32]);
      checks++; if (Kdrdy !== 1'b1) $display("[TB] FAIL kdrdy_high got=%b exp=1", Kdrdy); else passes++;
      checks++; if (Kin !== key) $display("[TB] FAIL kin got=%h exp=%h", Kin, key); else passes++;
      checks++; if (key_ok !== 1'b0) $display("[TB] FAIL key_ok_cleared got=%b exp=0", key_ok); else passes++;
      pulses = 1;
      repeat (kdelay) begin
         @(negedge CLK);
         if (Kdrdy) pulses++;
      end
      Kvld = 1'b1;
      @(negedge CLK);
      Kvld = 1'b0;
      checks++; if (pulses !== 1) $display("[TB] FAIL kdrdy_pulses got=%0d exp=1", pulses); else passes++;
      checks++; if ({key_ok, busy, timeout} !== 3'b100)
         $display("[TB] FAIL key_loaded got=%b exp=100 (delay %0d)", {key_ok, busy, timeout}, kdelay); else passes++;
   endtask

   task automatic test_encrypt(input logic [127:0] pt, input logic [127:0] ct, input int nload,
                               input logic extra, input int first_stall);
      int exp_cnt;
      int stall;
      logic [31:0] exp_word;
      exp_cnt = nload + int'(extra);
      if (exp_cnt > DL_MAX) exp_cnt = DL_MAX;
      for (int i = 0; i < 4; i++) write_word(1'b0, pt[127-32*i -: 32]);
      pulse_start();
      checks++; if (EN !== 1'b1) $display("[TB] FAIL en_high got=%b exp=1", EN); else passes++;
      checks++; if (Din !== pt) $display("[TB] FAIL enc_din got=%h exp=%h", Din, pt); else passes++;
      @(negedge CLK);
      checks++; if ({EN, busy} !== 2'b01) $display("[TB] FAIL en_one_cycle got=%b exp=01", {EN, busy}); else passes++;
      for (int i = 0; i < nload; i++) begin
         Dload = 1'b1;
         @(negedge CLK);
      end
      Dload = extra;
      Dvld  = 1'b1;
      Dout  = ct;
      @(negedge CLK);
      Dload = 1'b0;
      Dvld  = 1'b0;
      Dout  = {$urandom, $urandom, $urandom, $urandom};
      checks++; if (dload_cnt !== CNT_W'(exp_cnt)) $display("[TB] FAIL dload_cnt got=%0d exp=%0d", dload_cnt, exp_cnt); else passes++;
      for (int w = 0; w < 4; w++) begin
         exp_word = ct[127-32*w -: 32];
         stall = (w == 0) ? first_stall : int'($urandom_range(0, 2));
         repeat (stall) begin
            rd_ready = 1'b0;
            checks++; if ({rd_valid, rd_data} !== {1'b1, exp_word})
               $display("[TB] FAIL rd_stall w%0d got=%b/%h exp=1/%h", w, rd_valid, rd_data, exp_word); else passes++;
            @(negedge CLK);
         end
         checks++; if ({rd_valid, rd_data} !== {1'b1, exp_word})
            $display("[TB] FAIL rd_word w%0d got=%b/%h exp=1/%h", w, rd_valid, rd_data, exp_word); else passes++;
         rd_ready = 1'b1;
         @(negedge CLK);
         rd_ready = 1'b0;
      end
      checks++; if ({rd_valid, busy} !== 2'b00) $display("[TB] FAIL drain_done got=%b exp=00", {rd_valid, busy}); else passes++;
   endtask

   // Incomplete plaintext or a busy core must block start; stray Kvld/Dvld in IDLE are ignored.
   task automatic test_start_blocked(input logic [127:0] pt);
      for (int i = 0; i < 3; i++) write_word(1'b0, pt[127-32*i -: 32]);
      pulse_start();
      checks++; if ({EN, busy} !== 2'b00) $display("[TB] FAIL start_three_words got=%b exp=00", {EN, busy}); else passes++;
      write_word(1'b0, pt[31:0]);
      BSY = 1'b1;
      pulse_start();
      BSY = 1'b0;
      checks++; if ({EN, busy} !== 2'b00) $display("[TB] FAIL start_core_busy got=%b exp=00", {EN, busy}); else passes++;
      checks++; if (Din !== pt) $display("[TB] FAIL blocked_din got=%h exp=%h", Din, pt); else passes++;
      @(negedge CLK);
      Kvld = 1'b1;
      Dvld = 1'b1;
      @(negedge CLK);
      Kvld = 1'b0;
      Dvld = 1'b0;
      checks++; if ({key_ok, busy, rd_valid} !== 3'b100)
         $display("[TB] FAIL stray_handshake got=%b exp=100", {key_ok, busy, rd_valid}); else passes++;
   endtask

   task automatic test_timeout(input logic [127:0] pt);
      for (int i = 0; i < 4; i++) write_word(1'b0, pt[127-32*i -: 32]);
      pulse_start();
      checks++; if (EN !== 1'b1) $display("[TB] FAIL tmo_en got=%b exp=1", EN); else passes++;
      @(negedge CLK);
      repeat (TIMEOUT_CYC - 1) @(negedge CLK);
      checks++; if ({busy, timeout} !== 2'b10)
         $display("[TB] FAIL tmo_not_yet got=%b exp=10", {busy, timeout}); else passes++;
      @(negedge CLK);
      checks++; if ({timeout, key_ok, busy, wr_ready} !== 4'b1010)
         $display("[TB] FAIL tmo_err got=%b exp=1010", {timeout, key_ok, busy, wr_ready}); else passes++;
      pulse_start();
      checks++; if ({EN, timeout, busy} !== 3'b011) $display("[TB] FAIL err_start got=%b exp=011", {EN, timeout, busy}); else passes++;
      @(negedge CLK);
      clr_err = 1'b1;
      @(negedge CLK);
      clr_err = 1'b0;
      checks++; if ({timeout, busy, key_ok} !== 3'b000)
         $display("[TB] FAIL clr_err got=%b exp=000", {timeout, busy, key_ok}); else passes++;
   endtask

   // Plaintext count survives ERR, so start works without rewriting; then reset mid-wait.
   task automatic test_reset_mid(input logic [127:0] pt);
      pulse_start();
      checks++; if (EN !== 1'b1) $display("[TB] FAIL dcnt_kept_en got=%b exp=1", EN); else passes++;
      checks++; if (Din !== pt) $display("[TB] FAIL dcnt_kept_din got=%h exp=%h", Din, pt); else passes++;
      @(negedge CLK);
      repeat (3) begin
         Dload = 1'b1;
         @(negedge CLK);
      end
      Dload = 1'b0;
      checks++; if ({busy, dload_cnt} !== {1'b1, CNT_W'(3)})
         $display("[TB] FAIL pre_reset got=%b/%0d exp=1/3", busy, dload_cnt); else passes++;
      #2;
      RST = 1'b1;
      #1;
      checks++; if ({Kin, Din} !== 256'd0) $display("[TB] FAIL async_kin_din got=%h/%h exp=0", Kin, Din); else passes++;
      checks++; if ({Kdrdy, EN, rd_valid, key_ok, busy, timeout, rd_data, dload_cnt} !== '0)
         $display("[TB] FAIL async_outputs got=%b/%h/%0d exp=0", {Kdrdy, EN, rd_valid, key_ok, busy, timeout}, rd_data, dload_cnt);
      else passes++;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      checks++; if ({busy, wr_ready} !== 2'b01) $display("[TB] FAIL post_reset got=%b exp=01", {busy, wr_ready}); else passes++;
   endtask

   initial begin
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
      test_reset();
      test_start_no_key({$urandom, $urandom, $urandom, $urandom});
      test_key_load(128'h2B7E151628AED2A6ABF7158809CF4F3C, 10);
      test_encrypt(128'h3243F6A8885A308D313198A2E0370734,
                   128'h3925841D02DC09FBDC118597196A0B32, 5, 1'b0, 7);
      test_start_blocked({$urandom, $urandom, $urandom, $urandom});
      test_key_load({$urandom, $urandom, $urandom, $urandom}, TIMEOUT_CYC);
      test_encrypt({$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom}, 10, 1'b1, 0);
      for (int it = 0; it < 6; it++) begin
         if (it % 2 == 1) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            test_key_load(key, int'($urandom_range(1, TIMEOUT_CYC)));
         end
         pt = {$urandom, $urandom, $urandom, $urandom};
         ct = {$urandom, $urandom, $urandom, $urandom};
         test_encrypt(pt, ct, int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)));
      end
      timeout_pt = {$urandom, $urandom, $urandom, $urandom};
      test_timeout(timeout_pt);
      test_key_load({$urandom, $urandom, $urandom, $urandom}, 3);
      test_reset_mid(timeout_pt);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
